// File: rtl/izigzag.sv
// Inverse zigzag reorder buffer for the JPEG decode path.
// Coefficient pairs arrive in zigzag order (32 beats per 8x8 block) and are
// scattered into one of two 64-entry flop banks. Full banks drain as 8 raster
// rows, one row per beat, so one block can fill while the other empties.
// Coefficients are raw two's-complement words and pass through bit-exact.
module izigzag #(
    parameter int QW = 15
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0][QW-1:0]   d,
    input  logic                 d_valid,
    output logic                 d_hold,
    output logic [7:0][QW-1:0]   q,
    output logic [2:0]           q_cnt,
    output logic                 q_valid,
    input  logic                 q_hold
);

    // Zigzag index -> raster position (standard JPEG table).
    function automatic logic [5:0] zz_to_raster(input logic [5:0] idx);
        case (idx)
            6'd0:  zz_to_raster = 6'd0;   6'd1:  zz_to_raster = 6'd1;   6'd2:  zz_to_raster = 6'd8;   6'd3:  zz_to_raster = 6'd16;
            6'd4:  zz_to_raster = 6'd9;   6'd5:  zz_to_raster = 6'd2;   6'd6:  zz_to_raster = 6'd3;   6'd7:  zz_to_raster = 6'd10;
            6'd8:  zz_to_raster = 6'd17;  6'd9:  zz_to_raster = 6'd24;  6'd10: zz_to_raster = 6'd32;  6'd11: zz_to_raster = 6'd25;
            6'd12: zz_to_raster = 6'd18;  6'd13: zz_to_raster = 6'd11;  6'd14: zz_to_raster = 6'd4;   6'd15: zz_to_raster = 6'd5;
            6'd16: zz_to_raster = 6'd12;  6'd17: zz_to_raster = 6'd19;  6'd18: zz_to_raster = 6'd26;  6'd19: zz_to_raster = 6'd33;
            6'd20: zz_to_raster = 6'd40;  6'd21: zz_to_raster = 6'd48;  6'd22: zz_to_raster = 6'd41;  6'd23: zz_to_raster = 6'd34;
            6'd24: zz_to_raster = 6'd27;  6'd25: zz_to_raster = 6'd20;  6'd26: zz_to_raster = 6'd13;  6'd27: zz_to_raster = 6'd6;
            6'd28: zz_to_raster = 6'd7;   6'd29: zz_to_raster = 6'd14;  6'd30: zz_to_raster = 6'd21;  6'd31: zz_to_raster = 6'd28;
            6'd32: zz_to_raster = 6'd35;  6'd33: zz_to_raster = 6'd42;  6'd34: zz_to_raster = 6'd49;  6'd35: zz_to_raster = 6'd56;
            6'd36: zz_to_raster = 6'd57;  6'd37: zz_to_raster = 6'd50;  6'd38: zz_to_raster = 6'd43;  6'd39: zz_to_raster = 6'd36;
            6'd40: zz_to_raster = 6'd29;  6'd41: zz_to_raster = 6'd22;  6'd42: zz_to_raster = 6'd15;  6'd43: zz_to_raster = 6'd23;
            6'd44: zz_to_raster = 6'd30;  6'd45: zz_to_raster = 6'd37;  6'd46: zz_to_raster = 6'd44;  6'd47: zz_to_raster = 6'd51;
            6'd48: zz_to_raster = 6'd58;  6'd49: zz_to_raster = 6'd59;  6'd50: zz_to_raster = 6'd52;  6'd51: zz_to_raster = 6'd45;
            6'd52: zz_to_raster = 6'd38;  6'd53: zz_to_raster = 6'd31;  6'd54: zz_to_raster = 6'd39;  6'd55: zz_to_raster = 6'd46;
            6'd56: zz_to_raster = 6'd53;  6'd57: zz_to_raster = 6'd60;  6'd58: zz_to_raster = 6'd61;  6'd59: zz_to_raster = 6'd54;
            6'd60: zz_to_raster = 6'd47;  6'd61: zz_to_raster = 6'd55;  6'd62: zz_to_raster = 6'd62;  6'd63: zz_to_raster = 6'd63;
            default: zz_to_raster = 6'd0;
        endcase
    endfunction

    // Coefficient storage: two banks of 64 raster-ordered words.
    logic [QW-1:0]        bank_q [2][64];
    logic [QW-1:0]        bank_d [2][64];

    // Control state.
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 wptr_q, wptr_d;
    logic                 rptr_q, rptr_d;
    logic [4:0]           wcnt_q, wcnt_d;
    logic [2:0]           rcnt_q, rcnt_d;

    // Output registers.
    logic [7:0][QW-1:0]   q_q, q_d;
    logic [2:0]           q_cnt_q, q_cnt_d;
    logic                 q_valid_q, q_valid_d;

    // Handshake decode.
    logic                 wr_en_s;
    logic                 ld_en_s;
    logic [5:0]           wa0_s, wa1_s;

    // Accept/load decisions and the two raster addresses for this beat.
    always_comb begin
        wr_en_s = d_valid & ~bank_full_q[wptr_q];
        ld_en_s = bank_full_q[rptr_q] & (~q_valid_q | ~q_hold);
        wa0_s   = zz_to_raster({wcnt_q, 1'b0});
        wa1_s   = zz_to_raster({wcnt_q, 1'b1});
    end

    // Scatter an accepted coefficient pair into the write bank.
    always_comb begin
        bank_d = bank_q;
        if (wr_en_s) begin
            bank_d[wptr_q][wa0_s] = d[0];
            bank_d[wptr_q][wa1_s] = d[1];
        end else begin
            bank_d = bank_q;
        end
    end

    // Write beat counter and write bank pointer.
    always_comb begin
        wcnt_d = wcnt_q;
        wptr_d = wptr_q;
        if (wr_en_s) begin
            wcnt_d = wcnt_q + 5'd1;
            if (wcnt_q == 5'd31) begin
                wptr_d = ~wptr_q;
            end else begin
                wptr_d = wptr_q;
            end
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    // Bank full flags: set on the last write beat, cleared on the last row
    // load. The two events always target different banks, so both apply.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_en_s && (wcnt_q == 5'd31)) begin
            bank_full_d[wptr_q] = 1'b1;
        end else begin
            bank_full_d[wptr_q] = bank_full_q[wptr_q];
        end
        if (ld_en_s && (rcnt_q == 3'd7)) begin
            bank_full_d[rptr_q] = 1'b0;
        end else begin
            bank_full_d[rptr_q] = bank_full_d[rptr_q];
        end
    end

    // Output row register: load the next raster row, or drop valid once taken.
    always_comb begin
        q_d       = q_q;
        q_cnt_d   = q_cnt_q;
        q_valid_d = q_valid_q;
        rcnt_d    = rcnt_q;
        rptr_d    = rptr_q;
        if (ld_en_s) begin
            for (int c = 0; c < 8; c++) begin
                q_d[c[2:0]] = bank_q[rptr_q][{rcnt_q, c[2:0]}];
            end
            q_cnt_d   = rcnt_q;
            q_valid_d = 1'b1;
            rcnt_d    = rcnt_q + 3'd1;
            if (rcnt_q == 3'd7) begin
                rptr_d = ~rptr_q;
            end else begin
                rptr_d = rptr_q;
            end
        end else if (!q_hold) begin
            q_valid_d = 1'b0;
        end else begin
            q_valid_d = q_valid_q;
        end
    end

    // Coefficient banks carry no reset; the full flags gate every read.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bank_full_q <= 2'b00;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            wcnt_q      <= 5'd0;
            rcnt_q      <= 3'd0;
            q_q         <= '0;
            q_cnt_q     <= 3'd0;
            q_valid_q   <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            q_q         <= q_d;
            q_cnt_q     <= q_cnt_d;
            q_valid_q   <= q_valid_d;
        end
    end

    assign d_hold  = bank_full_q[wptr_q];
    assign q       = q_q;
    assign q_cnt   = q_cnt_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_izigzag.sv
// Directed and random-gap bench for the inverse zigzag reorder buffer.
module tb_izigzag;

    localparam int QW = 15;

    logic                clk = 1'b0;
    logic                resetn;
    logic [1:0][QW-1:0]  d;
    logic                d_valid;
    logic                d_hold;
    logic [7:0][QW-1:0]  q;
    logic [2:0]          q_cnt;
    logic                q_valid;
    logic                q_hold;

    int checks = 0;
    int passes = 0;
    int hold_mode = 0;   // 0: q_hold low, 1: q_hold high, 2: toggle every cycle
    bit hold_seen = 1'b0;

    int zz_tab [64] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
                        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    logic [QW-1:0]       blk [64];           // current block, zigzag order
    logic [7:0][QW-1:0]  exp_row [$];
    logic [2:0]          exp_cnt [$];
    logic [7:0][QW-1:0]  cap_row [$];
    logic [2:0]          cap_cnt [$];

    izigzag #(.QW(QW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .d       (d),
        .d_valid (d_valid),
        .d_hold  (d_hold),
        .q       (q),
        .q_cnt   (q_cnt),
        .q_valid (q_valid),
        .q_hold  (q_hold)
    );

    always #5 clk = ~clk;

    // Record every row that transfers on the coming edge, and any input stall.
    always @(negedge clk) begin
        if (resetn && q_valid && !q_hold) begin
            cap_row.push_back(q);
            cap_cnt.push_back(q_cnt);
        end
        if (resetn && d_hold) hold_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (hold_mode)
            1:       q_hold = 1'b1;
            2:       q_hold = ~q_hold;
            default: q_hold = 1'b0;
        endcase
    endtask

    // Reference reorder of blk into 8 expected raster rows.
    task automatic build_expected();
        logic [QW-1:0] ras [64];
        logic [7:0][QW-1:0] row;
        for (int i = 0; i < 64; i++) ras[zz_tab[i]] = blk[i];
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) row[c[2:0]] = ras[r * 8 + c];
            exp_row.push_back(row);
            exp_cnt.push_back(r[2:0]);
        end
    endtask

    // Present nbeats pairs of blk; leaves d_valid as it was on the last beat.
    task automatic drive_block(input int nbeats, input bit gaps);
        int waited;
        for (int n = 0; n < nbeats; n++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                d_valid = 1'b0;
                step();
            end
            d[0] = blk[2 * n];
            d[1] = blk[2 * n + 1];
            d_valid = 1'b1;
            waited = 0;
            while (d_hold && (waited < 300)) begin
                step();
                waited++;
            end
            if (waited >= 300) begin
                checks++;
                $display("FAIL beat_timeout: d_hold still 1 after %0d cycles at beat %0d, required 0", waited, n);
                return;
            end
            step();
        end
    endtask

    task automatic wait_rows(input int budget);
        d_valid = 1'b0;
        for (int i = 0; (i < budget) && (cap_row.size() < exp_row.size()); i++) step();
        repeat (4) step();
    endtask

    task automatic clear_queues();
        exp_row.delete(); exp_cnt.delete(); cap_row.delete(); cap_cnt.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0; d_valid = 1'b0; d = '0; hold_mode = 0; q_hold = 1'b0;
        step(); step();
        checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid: got %b required 0", q_valid); else passes++;
        checks++; if (q_cnt !== 3'd0) $display("FAIL reset_q_cnt: got %0d required 0", q_cnt); else passes++;
        checks++; if (d_hold !== 1'b0) $display("FAIL reset_d_hold: got %b required 0", d_hold); else passes++;
        checks++; if (q !== '0) $display("FAIL reset_q: got %h required 0", q); else passes++;
        resetn = 1'b1;
        step();
        clear_queues();
    endtask

    task automatic test_ramp();
        int r0 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
        int r7 [8] = '{35, 36, 48, 49, 57, 58, 62, 63};
        logic [7:0][QW-1:0] gr; logic [2:0] gc;
        for (int i = 0; i < 64; i++) blk[i] = QW'(i);
        build_expected();
        drive_block(32, 1'b0);
        d_valid = 1'b0;
        checks++; if (q_valid !== 1'b0) $display("FAIL ramp_latency_early: q_valid %b required 0", q_valid); else passes++;
        step();
        checks++; if (q_valid !== 1'b1) $display("FAIL ramp_latency: q_valid %b required 1", q_valid); else passes++;
        checks++; if (q_cnt !== 3'd0) $display("FAIL ramp_row0_cnt: got %0d required 0", q_cnt); else passes++;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (q[c[2:0]] !== QW'(r0[c])) $display("FAIL ramp_row0 col %0d: got %0d required %0d", c, q[c[2:0]], r0[c]);
            else passes++;
        end
        repeat (7) step();
        checks++; if (q_cnt !== 3'd7) $display("FAIL ramp_row7_cnt: got %0d required 7", q_cnt); else passes++;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (q[c[2:0]] !== QW'(r7[c])) $display("FAIL ramp_row7 col %0d: got %0d required %0d", c, q[c[2:0]], r7[c]);
            else passes++;
        end
        wait_rows(20);
        checks++; if (cap_row.size() != exp_row.size()) $display("FAIL ramp_rows: got %0d rows required %0d", cap_row.size(), exp_row.size()); else passes++;
        while ((cap_row.size() > 0) && (exp_row.size() > 0)) begin
            gr = cap_row.pop_front(); gc = cap_cnt.pop_front();
            checks++;
            if ((gr !== exp_row[0]) || (gc !== exp_cnt[0])) $display("FAIL ramp_row: got cnt %0d %h required cnt %0d %h", gc, gr, exp_cnt[0], exp_row[0]);
            else passes++;
            void'(exp_row.pop_front()); void'(exp_cnt.pop_front());
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        logic [7:0][QW-1:0] gr; logic [2:0] gc;
        hold_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) blk[i] = QW'(64 * k + i);
            build_expected();
            drive_block(32, 1'b0);
        end
        wait_rows(40);
        checks++; if (hold_seen !== 1'b0) $display("FAIL b2b_d_hold: got asserted required never"); else passes++;
        checks++; if (cap_row.size() != exp_row.size()) $display("FAIL b2b_rows: got %0d rows required %0d", cap_row.size(), exp_row.size()); else passes++;
        while ((cap_row.size() > 0) && (exp_row.size() > 0)) begin
            gr = cap_row.pop_front(); gc = cap_cnt.pop_front();
            checks++;
            if ((gr !== exp_row[0]) || (gc !== exp_cnt[0])) $display("FAIL b2b_row: got cnt %0d %h required cnt %0d %h", gc, gr, exp_cnt[0], exp_row[0]);
            else passes++;
            void'(exp_row.pop_front()); void'(exp_cnt.pop_front());
        end
        clear_queues();
    endtask

    task automatic test_output_stall();
        logic [7:0][QW-1:0] snap, gr; logic [2:0] gc;
        hold_mode = 1; q_hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) blk[i] = QW'(1000 * (k + 1) + i);
            build_expected();
            drive_block(32, 1'b0);
        end
        checks++; if (d_hold !== 1'b1) $display("FAIL stall_d_hold: got %b required 1", d_hold); else passes++;
        checks++; if (q_valid !== 1'b1) $display("FAIL stall_q_valid: got %b required 1", q_valid); else passes++;
        checks++; if (q_cnt !== 3'd0) $display("FAIL stall_q_cnt: got %0d required 0", q_cnt); else passes++;
        checks++; if (q !== exp_row[0]) $display("FAIL stall_row0: got %h required %h", q, exp_row[0]); else passes++;
        snap = q;
        for (int i = 0; i < 64; i++) blk[i] = QW'(3000 + i);
        build_expected();
        d[0] = blk[0]; d[1] = blk[1]; d_valid = 1'b1;
        repeat (36) step();
        checks++; if (q !== snap) $display("FAIL stall_q_stable: got %h required %h", q, snap); else passes++;
        checks++; if (d_hold !== 1'b1) $display("FAIL stall_d_hold_kept: got %b required 1", d_hold); else passes++;
        checks++; if (cap_row.size() != 0) $display("FAIL stall_no_transfer: got %0d rows required 0", cap_row.size()); else passes++;
        hold_mode = 0; q_hold = 1'b0;
        repeat (6) step();
        checks++; if (q_cnt !== 3'd6) $display("FAIL stall_drain_cnt6: got %0d required 6", q_cnt); else passes++;
        checks++; if (d_hold !== 1'b1) $display("FAIL stall_d_hold_row6: got %b required 1", d_hold); else passes++;
        step();
        checks++; if (q_cnt !== 3'd7) $display("FAIL stall_drain_cnt7: got %0d required 7", q_cnt); else passes++;
        checks++; if (d_hold !== 1'b0) $display("FAIL stall_d_hold_release: got %b required 0", d_hold); else passes++;
        drive_block(32, 1'b0);
        wait_rows(60);
        checks++; if (cap_row.size() != exp_row.size()) $display("FAIL stall_rows: got %0d rows required %0d", cap_row.size(), exp_row.size()); else passes++;
        while ((cap_row.size() > 0) && (exp_row.size() > 0)) begin
            gr = cap_row.pop_front(); gc = cap_cnt.pop_front();
            checks++;
            if ((gr !== exp_row[0]) || (gc !== exp_cnt[0])) $display("FAIL stall_row: got cnt %0d %h required cnt %0d %h", gc, gr, exp_cnt[0], exp_row[0]);
            else passes++;
            void'(exp_row.pop_front()); void'(exp_cnt.pop_front());
        end
        clear_queues();
    endtask

    task automatic test_random();
        logic [7:0][QW-1:0] gr; logic [2:0] gc;
        hold_mode = 2;
        for (int b = 0; b < 50; b++) begin
            for (int i = 0; i < 64; i++) blk[i] = QW'($urandom);
            build_expected();
            drive_block(32, 1'b1);
        end
        wait_rows(200);
        hold_mode = 0;
        step();
        checks++; if (cap_row.size() != exp_row.size()) $display("FAIL random_rows: got %0d rows required %0d", cap_row.size(), exp_row.size()); else passes++;
        while ((cap_row.size() > 0) && (exp_row.size() > 0)) begin
            gr = cap_row.pop_front(); gc = cap_cnt.pop_front();
            checks++;
            if ((gr !== exp_row[0]) || (gc !== exp_cnt[0])) $display("FAIL random_row: got cnt %0d %h required cnt %0d %h", gc, gr, exp_cnt[0], exp_row[0]);
            else passes++;
            void'(exp_row.pop_front()); void'(exp_cnt.pop_front());
        end
        clear_queues();
    endtask

    task automatic test_extremes();
        logic [7:0][QW-1:0] gr; logic [2:0] gc;
        for (int i = 0; i < 64; i++) blk[i] = '0;
        blk[0]  = 15'h3FFF;   // +16383
        blk[63] = 15'h4000;   // -16384
        build_expected();
        drive_block(32, 1'b0);
        wait_rows(20);
        checks++;
        if (cap_row.size() < 8) $display("FAIL extreme_rows: got %0d rows required 8", cap_row.size());
        else if (cap_row[0][0] !== 15'h3FFF) $display("FAIL extreme_pos: got %h required 3fff", cap_row[0][0]);
        else passes++;
        checks++;
        if (cap_row.size() < 8) $display("FAIL extreme_rows: got %0d rows required 8", cap_row.size());
        else if (cap_row[7][7] !== 15'h4000) $display("FAIL extreme_neg: got %h required 4000", cap_row[7][7]);
        else passes++;
        while ((cap_row.size() > 0) && (exp_row.size() > 0)) begin
            gr = cap_row.pop_front(); gc = cap_cnt.pop_front();
            checks++;
            if ((gr !== exp_row[0]) || (gc !== exp_cnt[0])) $display("FAIL extreme_row: got cnt %0d %h required cnt %0d %h", gc, gr, exp_cnt[0], exp_row[0]);
            else passes++;
            void'(exp_row.pop_front()); void'(exp_cnt.pop_front());
        end
        clear_queues();
    endtask

    task automatic test_reset_mid();
        logic [7:0][QW-1:0] gr; logic [2:0] gc;
        hold_mode = 1; q_hold = 1'b1;
        for (int i = 0; i < 64; i++) blk[i] = QW'(5000 + i);
        drive_block(32, 1'b0);
        for (int i = 0; i < 64; i++) blk[i] = QW'(6000 + i);
        drive_block(17, 1'b0);
        checks++; if (q_valid !== 1'b1) $display("FAIL rstmid_setup_q_valid: got %b required 1", q_valid); else passes++;
        resetn = 1'b0; d_valid = 1'b0;
        step();
        checks++; if (q_valid !== 1'b0) $display("FAIL rstmid_q_valid: got %b required 0", q_valid); else passes++;
        checks++; if (q_cnt !== 3'd0) $display("FAIL rstmid_q_cnt: got %0d required 0", q_cnt); else passes++;
        checks++; if (d_hold !== 1'b0) $display("FAIL rstmid_d_hold: got %b required 0", d_hold); else passes++;
        resetn = 1'b1; hold_mode = 0; q_hold = 1'b0;
        step();
        clear_queues();
        for (int i = 0; i < 64; i++) blk[i] = QW'(7000 + 3 * i);
        build_expected();
        drive_block(32, 1'b0);
        wait_rows(20);
        checks++; if (cap_row.size() != exp_row.size()) $display("FAIL rstmid_rows: got %0d rows required %0d", cap_row.size(), exp_row.size()); else passes++;
        while ((cap_row.size() > 0) && (exp_row.size() > 0)) begin
            gr = cap_row.pop_front(); gc = cap_cnt.pop_front();
            checks++;
            if ((gr !== exp_row[0]) || (gc !== exp_cnt[0])) $display("FAIL rstmid_row: got cnt %0d %h required cnt %0d %h", gc, gr, exp_cnt[0], exp_row[0]);
            else passes++;
            void'(exp_row.pop_front()); void'(exp_cnt.pop_front());
        end
        clear_queues();
    endtask

    initial begin
        resetn = 1'b0; d_valid = 1'b0; d = '0; q_hold = 1'b0;
        test_reset();
        test_ramp();
        test_back_to_back();
        test_output_stall();
        test_random();
        test_extremes();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
